// File: rtl/score_pkg.sv
// Shared types and seven-segment constants for the score counter.
package score_pkg;

  typedef logic [6:0] seg7_t;
  typedef logic [3:0] bcd_digit_t;

  // Active-low segments, bit order {g,f,e,d,c,b,a}
  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low seven-segment decoder with blanking.
module seg7_decode
  import score_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       blank,
  output seg7_t      seg
);

  // Blank overrides the digit; non-BCD codes also show blank
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_counter.sv
// Multi-digit BCD score counter with edge-detected inc/dec, saturate or
// wrap at MAX_SCORE, floor at zero, and seven-segment outputs.
module score_counter
  import score_pkg::*;
#(
  parameter int NUM_DIGITS    = 2,
  parameter int MAX_SCORE     = 99,
  parameter bit SATURATE      = 1'b1,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    inc,
  input  logic                    dec,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    at_max,
  output logic                    rollover
);

  // Binary to packed BCD, used only to build the MAX_SCORE compare constant
  function automatic logic [4*NUM_DIGITS-1:0] to_bcd(input int value);
    logic [4*NUM_DIGITS-1:0] r;
    int t;
    r = '0;
    t = value;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  localparam logic [4*NUM_DIGITS-1:0] MAX_BCD = to_bcd(MAX_SCORE);

  generate
    if (NUM_DIGITS < 1 || NUM_DIGITS > 6) begin : g_bad_digits
      $error("score_counter: NUM_DIGITS must be 1..6");
    end
    if (MAX_SCORE < 0 || MAX_SCORE > (10 ** NUM_DIGITS) - 1) begin : g_bad_max
      $error("score_counter: MAX_SCORE does not fit in NUM_DIGITS BCD digits");
    end
  endgenerate

  bcd_digit_t [NUM_DIGITS-1:0] score;
  bcd_digit_t [NUM_DIGITS-1:0] score_inc;
  bcd_digit_t [NUM_DIGITS-1:0] score_dec;
  seg7_t      [NUM_DIGITS-1:0] seg;
  logic       [NUM_DIGITS-1:0] blank;
  logic inc_q, dec_q;
  logic inc_rise, dec_rise;
  logic is_zero;

  assign inc_rise  = inc & ~inc_q;
  assign dec_rise  = dec & ~dec_q;
  assign is_zero   = (score == '0);
  assign at_max    = (score == MAX_BCD);
  assign score_bcd = score;
  assign hex       = seg;

  // BCD ripple-carry increment: a 9 rolls to 0 and carries upward
  always_comb begin
    logic carry;
    score_inc = score;
    carry     = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (carry) begin
        if (score[i] == 4'd9) begin
          score_inc[i] = 4'd0;
        end else begin
          score_inc[i] = score[i] + 4'd1;
          carry        = 1'b0;
        end
      end
    end
  end

  // BCD ripple-borrow decrement: a 0 becomes 9 and borrows upward
  always_comb begin
    logic borrow;
    score_dec = score;
    borrow    = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (borrow) begin
        if (score[i] == 4'd0) begin
          score_dec[i] = 4'd9;
        end else begin
          score_dec[i] = score[i] - 4'd1;
          borrow       = 1'b0;
        end
      end
    end
  end

  // Score state, edge-detect history and the one-cycle rollover pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score    <= '0;
      inc_q    <= 1'b0;
      dec_q    <= 1'b0;
      rollover <= 1'b0;
    end else begin
      // history always tracks the inputs, even while clear is active
      inc_q    <= inc;
      dec_q    <= dec;
      rollover <= 1'b0;
      if (clear) begin
        score <= '0;
      end else if (inc_rise && dec_rise) begin
        score <= score;
      end else if (inc_rise) begin
        if (at_max) begin
          if (!SATURATE) begin
            score    <= '0;
            rollover <= 1'b1;
          end
        end else begin
          score <= score_inc;
        end
      end else if (dec_rise) begin
        if (!is_zero) begin
          score <= score_dec;
        end
      end
    end
  end

  // Per-digit blanking and decode; digit 0 is never blanked
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
      if (gi == 0) begin : g_low
        assign blank[gi] = 1'b0;
      end else begin : g_high
        assign blank[gi] = BLANK_LEADING && (score[NUM_DIGITS-1:gi] == '0);
      end
      seg7_decode u_dec (
        .digit (score[gi]),
        .blank (blank[gi]),
        .seg   (seg[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_score_counter.sv
// Directed-vector bench: saturating 0..99 counter with blanking, and a
// wrapping 0..15 counter without blanking, sharing clock and reset.
module tb_score_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic clear_a = 1'b0, inc_a = 1'b0, dec_a = 1'b0;
  logic clear_w = 1'b0, inc_w = 1'b0, dec_w = 1'b0;
  logic [7:0]  bcd_a, bcd_w;
  logic [13:0] hex_a, hex_w;
  logic max_a, max_w, ro_a, ro_w;

  int errs = 0;
  int checks = 0;
  int ro_a_cnt = 0;
  int ro_w_cnt = 0;

  always #5 clk = ~clk;

  score_counter #(.NUM_DIGITS(2), .MAX_SCORE(99), .SATURATE(1'b1), .BLANK_LEADING(1'b1)) dut_a (
    .clk(clk), .reset(reset), .clear(clear_a), .inc(inc_a), .dec(dec_a),
    .score_bcd(bcd_a), .hex(hex_a), .at_max(max_a), .rollover(ro_a)
  );

  score_counter #(.NUM_DIGITS(2), .MAX_SCORE(15), .SATURATE(1'b0), .BLANK_LEADING(1'b0)) dut_w (
    .clk(clk), .reset(reset), .clear(clear_w), .inc(inc_w), .dec(dec_w),
    .score_bcd(bcd_w), .hex(hex_w), .at_max(max_w), .rollover(ro_w)
  );

  always @(negedge clk) begin
    if (ro_a) ro_a_cnt++;
    if (ro_w) ro_w_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Raise the selected request(s) for 'hold' posedges, then drop for one
  task automatic pulse(input bit w, input bit pi, input bit pd, input int hold);
    @(negedge clk);
    if (w) begin inc_w = pi; dec_w = pd; end
    else   begin inc_a = pi; dec_a = pd; end
    repeat (hold) @(negedge clk);
    inc_a = 1'b0; dec_a = 1'b0; inc_w = 1'b0; dec_w = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_bcd_a", bcd_a, 8'h00);
    chk("rst_hex_a", hex_a, 14'b1111111_1000000);
    chk("rst_max_a", max_a, 0);
    chk("rst_ro_a",  ro_a,  0);
    chk("rst_hex_w", hex_w, 14'b1000000_1000000);

    // 12 long holds, each counted once
    for (int i = 0; i < 12; i++) pulse(0, 1, 0, 5);
    chk("hold12_bcd", bcd_a, 8'h12);
    chk("hold12_hex", hex_a, 14'b1111001_0100100);

    // saturate at 99
    @(negedge clk); clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    chk("clr_bcd", bcd_a, 8'h00);
    for (int i = 0; i < 98; i++) pulse(0, 1, 0, 1);
    chk("sat98_bcd", bcd_a, 8'h98);
    chk("sat98_max", max_a, 0);
    pulse(0, 1, 0, 1);
    chk("sat99_bcd", bcd_a, 8'h99);
    chk("sat99_max", max_a, 1);
    chk("sat99_hex", hex_a, 14'b0010000_0010000);
    pulse(0, 1, 0, 1);
    chk("sat100_bcd", bcd_a, 8'h99);
    chk("sat100_max", max_a, 1);
    chk("sat_ro_cnt", ro_a_cnt, 0);

    // decrement with borrow, blanking, floor
    @(negedge clk); clear_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    for (int i = 0; i < 10; i++) pulse(0, 1, 0, 2);
    chk("dec10_bcd", bcd_a, 8'h10);
    chk("dec10_hex", hex_a, 14'b1111001_1000000);
    pulse(0, 0, 1, 3);
    chk("dec09_bcd", bcd_a, 8'h09);
    chk("dec09_hex", hex_a, 14'b1111111_0010000);
    for (int i = 0; i < 10; i++) pulse(0, 0, 1, 1);
    chk("floor_bcd", bcd_a, 8'h00);
    chk("floor_hex", hex_a, 14'b1111111_1000000);

    // simultaneous inc and dec rise holds
    for (int i = 0; i < 5; i++) pulse(0, 1, 0, 1);
    chk("both_pre", bcd_a, 8'h05);
    pulse(0, 1, 1, 2);
    chk("both_bcd", bcd_a, 8'h05);

    // clear wins over a same-cycle inc rise, and the rise is consumed
    pulse(0, 1, 0, 1);
    pulse(0, 1, 0, 1);
    chk("pre_clr07", bcd_a, 8'h07);
    @(negedge clk); clear_a = 1'b1; inc_a = 1'b1;
    @(negedge clk); clear_a = 1'b0;
    chk("clrinc_bcd", bcd_a, 8'h00);
    @(negedge clk); inc_a = 1'b0;
    chk("clrinc_hold", bcd_a, 8'h00);

    // wrap at 15 on the second instance
    for (int i = 0; i < 15; i++) pulse(1, 1, 0, 1);
    chk("wrap15_bcd", bcd_w, 8'h15);
    chk("wrap15_max", max_w, 1);
    chk("wrap15_hex", hex_w, 14'b1111001_0010010);
    @(negedge clk); inc_w = 1'b1;
    @(negedge clk);
    chk("wrap_bcd",  bcd_w, 8'h00);
    chk("wrap_ro1",  ro_w,  1);
    chk("wrap_max",  max_w, 0);
    chk("wrap_hex",  hex_w, 14'b1000000_1000000);
    inc_w = 1'b0;
    @(negedge clk);
    chk("wrap_ro0",  ro_w,  0);
    chk("wrap_ro_cnt", ro_w_cnt, 1);

    // async reset between edges
    for (int i = 0; i < 7; i++) pulse(0, 1, 0, 1);
    chk("pre_rst07", bcd_a, 8'h07);
    #2 reset = 1'b1;
    #1;
    chk("arst_bcd", bcd_a, 8'h00);
    chk("arst_hex", hex_a, 14'b1111111_1000000);
    chk("arst_max", max_a, 0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_bcd", bcd_a, 8'h00);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  // hard bound on total run time
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
